// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake into the GMII TX framer.
// The master drives the bytes and the slave returns s_ready.
interface gmii_tx_framer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII TX framer: preamble/SFD insertion, zero padding, CRC32 FCS, IFG.
// All GMII outputs are registered; s_ready decodes straight from state.
module gmii_tx_framer #(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic             gmii_tx_clk,
  input  logic             reset,
  gmii_tx_framer_if.slave  up,
  output logic             gmii_tx_en,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_er,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_underrun
);

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP
  } state_t;

  localparam logic [10:0] MINF     = 11'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  state_t      r_state, w_state;
  logic [31:0] r_crc, w_crc;
  logic [10:0] r_cnt, w_cnt;
  logic [2:0]  r_bcnt, w_bcnt;
  logic [15:0] r_icnt, w_icnt;
  logic        r_good, w_good;
  logic        r_en, w_en;
  logic [7:0]  r_txd, w_txd;
  logic        r_er, w_er;
  logic        r_done, w_done;
  logic        r_urun, w_urun;
  logic        w_ready;
  logic [10:0] w_cnt_inc;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_byte;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  assign w_cnt_inc = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  assign w_fcs     = ~r_crc;

  always_comb begin
    w_fcs_byte = w_fcs[7:0];
    unique case (r_bcnt[1:0])
      2'd0: w_fcs_byte = w_fcs[7:0];
      2'd1: w_fcs_byte = w_fcs[15:8];
      2'd2: w_fcs_byte = w_fcs[23:16];
      2'd3: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_crc   = r_crc;
    w_cnt   = r_cnt;
    w_bcnt  = r_bcnt;
    w_icnt  = r_icnt;
    w_good  = r_good;
    w_en    = 1'b0;
    w_txd   = 8'h00;
    w_er    = 1'b0;
    w_done  = 1'b0;
    w_urun  = 1'b0;
    w_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (up.s_valid) begin
          w_state = PRE;
          w_en    = 1'b1;
          w_txd   = 8'h55;
          w_bcnt  = 3'd0;
          w_cnt   = 11'd0;
          w_crc   = 32'hFFFFFFFF;
        end
      end
      PRE: begin
        w_en   = 1'b1;
        w_txd  = 8'h55;
        w_bcnt = r_bcnt + 3'd1;
        if (r_bcnt == 3'd5) w_state = SFD;
      end
      SFD: begin
        w_en    = 1'b1;
        w_txd   = 8'hD5;
        w_state = DATA;
      end
      DATA: begin
        w_ready = 1'b1;
        if (up.s_valid) begin
          w_en  = 1'b1;
          w_txd = up.s_data;
          w_crc = crc_byte(r_crc, up.s_data);
          w_cnt = w_cnt_inc;
          if (up.s_last) begin
            w_bcnt  = 3'd0;
            w_state = (w_cnt_inc < MINF) ? PAD : FCS;
          end
        end else begin
          // Underrun: poison the frame with one error byte
          w_en    = 1'b1;
          w_er    = 1'b1;
          w_urun  = 1'b1;
          w_state = DROP;
        end
      end
      PAD: begin
        w_en  = 1'b1;
        w_crc = crc_byte(r_crc, 8'h00);
        w_cnt = w_cnt_inc;
        if (w_cnt_inc >= MINF) begin
          w_bcnt  = 3'd0;
          w_state = FCS;
        end
      end
      FCS: begin
        w_en   = 1'b1;
        w_txd  = w_fcs_byte;
        w_bcnt = r_bcnt + 3'd1;
        if (r_bcnt == 3'd3) begin
          w_state = IFG;
          w_icnt  = 16'd0;
          w_good  = 1'b1;
        end
      end
      IFG: begin
        w_icnt = r_icnt + 16'd1;
        w_done = r_good && (r_icnt == 16'd0);
        if (r_icnt >= IFG_LAST) begin
          w_state = IDLE;
          w_good  = 1'b0;
        end
      end
      DROP: begin
        w_ready = 1'b1;
        if (up.s_valid && up.s_last) begin
          w_state = IFG;
          w_icnt  = 16'd0;
          w_good  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_crc   <= 32'hFFFFFFFF;
      r_cnt   <= 11'd0;
      r_bcnt  <= 3'd0;
      r_icnt  <= 16'd0;
      r_good  <= 1'b0;
      r_en    <= 1'b0;
      r_txd   <= 8'h00;
      r_er    <= 1'b0;
      r_done  <= 1'b0;
      r_urun  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_crc   <= w_crc;
      r_cnt   <= w_cnt;
      r_bcnt  <= w_bcnt;
      r_icnt  <= w_icnt;
      r_good  <= w_good;
      r_en    <= w_en;
      r_txd   <= w_txd;
      r_er    <= w_er;
      r_done  <= w_done;
      r_urun  <= w_urun;
    end
  end

  assign up.s_ready  = w_ready;
  assign gmii_tx_en  = r_en;
  assign gmii_txd    = r_txd;
  assign gmii_tx_er  = r_er;
  assign tx_busy     = (r_state != IDLE);
  assign tx_done     = r_done;
  assign tx_underrun = r_urun;

endmodule
